fp_addsub_issue: RTL and testbench

//  Operand queue and result stage wrapped around the combinational FP_Adder_Sub.

---
 rtl/fp_addsub_issue.sv | 147 ++++++++++++++
 tb/tb_fp_addsub_issue.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_addsub_issue.sv
// Operand FIFO plus registered issue (S1) and result (S2) stages around an external
// combinational FP adder/subtractor; valid/ready on both the request and result sides.
module fp_addsub_issue #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [31:0]                in_a,
  input  logic [31:0]                in_b,
  input  logic [2:0]                 in_opcode,
  input  logic [TAG_W-1:0]           in_tag,
  output logic [31:0]                fpu_a,
  output logic [31:0]                fpu_b,
  output logic                       fpu_cin,
  output logic [2:0]                 fpu_opcode,
  input  logic [31:0]                fpu_out,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [31:0]                out_result,
  output logic [TAG_W-1:0]           out_tag,
  output logic                       out_zero,
  output logic                       out_inf,
  output logic                       out_nan,
  output logic [$clog2(DEPTH):0]     fifo_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = 32 + 32 + 3 + TAG_W;

  function automatic logic is_zero_f(input logic [31:0] v);
    return (v[30:23] == 8'h00) && (v[22:0] == 23'h000000);
  endfunction

  function automatic logic is_inf_f(input logic [31:0] v);
    return (v[30:23] == 8'hFF) && (v[22:0] == 23'h000000);
  endfunction

  function automatic logic is_nan_f(input logic [31:0] v);
    return (v[30:23] == 8'hFF) && (v[22:0] != 23'h000000);
  endfunction

  logic [ENT_W-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;

  logic             s1_valid_r;
  logic [31:0]      s1_a_r;
  logic [31:0]      s1_b_r;
  logic [2:0]       s1_op_r;
  logic [TAG_W-1:0] s1_tag_r;

  logic             s2_valid_r;
  logic [31:0]      s2_result_r;
  logic [TAG_W-1:0] s2_tag_r;
  logic             s2_zero_r;
  logic             s2_inf_r;
  logic             s2_nan_r;

  logic             in_ready_s;
  logic             push_s;
  logic             s1_adv_s;
  logic             s2_adv_s;
  logic [ENT_W-1:0] head_s;

  // Handshake and stage-advance decisions from registered state.
  always_comb begin
    in_ready_s = (count_r != CNT_W'(DEPTH));
    push_s     = in_valid && in_ready_s;
    s2_adv_s   = s1_valid_r && (!s2_valid_r || out_ready);
    s1_adv_s   = (count_r != CNT_W'(0)) && (!s1_valid_r || s2_adv_s);
    head_s     = mem_r[rd_ptr_r];
  end

  // FIFO storage/pointers and both pipeline stages; flush clears only the valids and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_r[i] <= '0;
      wr_ptr_r    <= '0;
      rd_ptr_r    <= '0;
      count_r     <= '0;
      s1_valid_r  <= 1'b0;
      s1_a_r      <= 32'h0000_0000;
      s1_b_r      <= 32'h0000_0000;
      s1_op_r     <= 3'd0;
      s1_tag_r    <= '0;
      s2_valid_r  <= 1'b0;
      s2_result_r <= 32'h0000_0000;
      s2_tag_r    <= '0;
      s2_zero_r   <= 1'b0;
      s2_inf_r    <= 1'b0;
      s2_nan_r    <= 1'b0;
    end else if (flush) begin
      wr_ptr_r   <= '0;
      rd_ptr_r   <= '0;
      count_r    <= '0;
      s1_valid_r <= 1'b0;
      s2_valid_r <= 1'b0;
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_r] <= {in_a, in_b, in_opcode, in_tag};
        wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
      end
      if (s1_adv_s) rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      case ({push_s, s1_adv_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
      if (s1_adv_s) begin
        {s1_a_r, s1_b_r, s1_op_r, s1_tag_r} <= head_s;
        s1_valid_r <= 1'b1;
      end else if (s2_adv_s) begin
        s1_valid_r <= 1'b0;
      end
      if (s2_adv_s) begin
        s2_result_r <= fpu_out;
        s2_tag_r    <= s1_tag_r;
        s2_zero_r   <= is_zero_f(fpu_out);
        s2_inf_r    <= is_inf_f(fpu_out);
        s2_nan_r    <= is_nan_f(fpu_out);
        s2_valid_r  <= 1'b1;
      end else if (out_ready) begin
        s2_valid_r  <= 1'b0;
      end
    end
  end

  assign in_ready   = in_ready_s;
  assign fifo_count = count_r;
  assign fpu_a      = s1_a_r;
  assign fpu_b      = s1_b_r;
  assign fpu_cin    = 1'b0;
  assign fpu_opcode = s1_op_r;
  assign out_valid  = s2_valid_r;
  assign out_result = s2_result_r;
  assign out_tag    = s2_tag_r;
  assign out_zero   = s2_zero_r;
  assign out_inf    = s2_inf_r;
  assign out_nan    = s2_nan_r;

endmodule

// File: tb/tb_fp_addsub_issue.sv
// Bench for fp_addsub_issue: behavioural FPU stand-in, scoreboard queue of expected
// results in request order, directed scenarios plus a randomized stream.
module tb_fp_addsub_issue;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_a = 32'h0;
  logic [31:0] in_b = 32'h0;
  logic [2:0]  in_opcode = 3'd0;
  logic [3:0]  in_tag = 4'd0;
  logic [31:0] fpu_a, fpu_b, fpu_out;
  logic        fpu_cin;
  logic [2:0]  fpu_opcode;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_result;
  logic [3:0]  out_tag;
  logic        out_zero, out_inf, out_nan;
  logic [2:0]  fifo_count;

  int n_checks = 0;
  int n_fail   = 0;

  fp_addsub_issue #(.DEPTH(4), .TAG_W(4)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_opcode(in_opcode), .in_tag(in_tag),
    .fpu_a(fpu_a), .fpu_b(fpu_b), .fpu_cin(fpu_cin), .fpu_opcode(fpu_opcode),
    .fpu_out(fpu_out),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_tag(out_tag),
    .out_zero(out_zero), .out_inf(out_inf), .out_nan(out_nan),
    .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  // Normal single <-> double conversions so opcode 0 can do a true FP add.
  function automatic real sp2real(input logic [31:0] v);
    logic [10:0] e;
    e = {3'b000, v[30:23]} + 11'd896;
    return $bitstoreal({v[31], e, v[22:0], 29'd0});
  endfunction

  function automatic logic [31:0] real2sp(input real r);
    logic [63:0] d;
    logic [10:0] e;
    d = $realtobits(r);
    e = d[62:52] - 11'd896;
    return {d[63], e[7:0], d[51:29]};
  endfunction

  // Stand-in adder: op 0 real add, op 7 passes A, others an arbitrary deterministic mix.
  function automatic logic [31:0] fpu_fn(input logic [31:0] a, input logic [31:0] b,
                                         input logic [2:0] op);
    if (op == 3'd0) return real2sp(sp2real(a) + sp2real(b));
    if (op == 3'd7) return a;
    return (a ^ {b[15:0], b[31:16]}) + {29'd0, op};
  endfunction

  always_comb fpu_out = fpu_fn(fpu_a, fpu_b, fpu_opcode);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct packed {
    logic [31:0] res;
    logic [3:0]  tag;
  } exp_t;

  exp_t        q[$];
  logic        stall_prev = 1'b0;
  logic [31:0] res_prev;
  logic [3:0]  tag_prev;

  // Scoreboard: sampled at negedge, predicting what the next rising edge accepts/consumes.
  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      stall_prev = 1'b0;
    end else begin
      chk("in_ready_vs_count", {31'd0, in_ready}, {31'd0, fifo_count != 3'd4});
      if (stall_prev) begin
        chk("stall_hold_result", out_result, res_prev);
        chk("stall_hold_tag", {28'd0, out_tag}, {28'd0, tag_prev});
      end
      if (flush) begin
        q.delete();
        stall_prev = 1'b0;
      end else begin
        if (out_valid) begin
          if (q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_result: tag %h result %h with nothing pending", out_tag, out_result);
          end else begin
            chk("result", out_result, q[0].res);
            chk("tag", {28'd0, out_tag}, {28'd0, q[0].tag});
            chk("flags", {29'd0, out_zero, out_inf, out_nan},
                {29'd0, q[0].res[30:23] == 8'h00 && q[0].res[22:0] == 23'd0,
                        q[0].res[30:23] == 8'hFF && q[0].res[22:0] == 23'd0,
                        q[0].res[30:23] == 8'hFF && q[0].res[22:0] != 23'd0});
            if (out_ready) void'(q.pop_front());
          end
        end
        if (in_valid && in_ready) q.push_back('{res: fpu_fn(in_a, in_b, in_opcode), tag: in_tag});
        stall_prev = out_valid && !out_ready;
        res_prev   = out_result;
        tag_prev   = out_tag;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                       input logic [3:0] tag);
    in_valid  = 1'b1;
    in_a      = a;
    in_b      = b;
    in_opcode = op;
    in_tag    = tag;
  endtask

  // Offer ops with rising tags until n are accepted (bounded).
  task automatic push_n(input int n, input logic [3:0] tag0, output int accepted);
    logic acc;
    accepted = 0;
    for (int c = 0; c < 40 && accepted < n; c++) begin
      drive($urandom, $urandom, 3'($urandom_range(1, 6)), tag0 + 4'(accepted));
      @(negedge clk);
      acc = in_ready;
      step();
      if (acc) accepted++;
    end
    in_valid = 1'b0;
  endtask

  task automatic check_reset_values(input string pfx);
    chk({pfx, "_out_valid"}, {31'd0, out_valid}, 32'd0);
    chk({pfx, "_fifo_count"}, {29'd0, fifo_count}, 32'd0);
    chk({pfx, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    chk({pfx, "_fpu_a"}, fpu_a, 32'd0);
    chk({pfx, "_fpu_opcode"}, {29'd0, fpu_opcode}, 32'd0);
    chk({pfx, "_out_result"}, out_result, 32'd0);
    chk({pfx, "_out_tag_flags"}, {25'd0, out_tag, out_zero, out_inf, out_nan}, 32'd0);
  endtask

  logic [31:0] specials [3] = '{32'h8000_0000, 32'h7F80_0000, 32'h7FC0_0000};
  logic [2:0]  spec_flags [3] = '{3'b100, 3'b010, 3'b001};

  initial begin
    int          accepted;
    logic [31:0] held_res, held_a;

    repeat (2) @(posedge clk);
    #1;
    check_reset_values("reset");
    rst = 1'b0;
    check_reset_values("post_reset");
    chk("fpu_cin", {31'd0, fpu_cin}, 32'd0);

    // 1: real add, two-cycle latency after accept.
    out_ready = 1'b1;
    drive(32'h3FC0_0000, 32'h4010_0000, 3'd0, 4'd3);
    step();
    in_valid = 1'b0;
    chk("t1_valid_n", {31'd0, out_valid}, 32'd0);
    step();
    chk("t1_valid_n1", {31'd0, out_valid}, 32'd0);
    step();
    chk("t1_valid_n2", {31'd0, out_valid}, 32'd1);
    chk("t1_result", out_result, 32'h4070_0000);
    chk("t1_tag", {28'd0, out_tag}, 32'd3);
    step();

    // 2: back-to-back stream, one result per cycle in tag order.
    for (int k = 0; k < 10; k++) begin
      if (k < 8) drive($urandom, $urandom, 3'($urandom_range(1, 6)), 4'(k));
      else in_valid = 1'b0;
      step();
      if (k >= 2) begin
        chk("t2_no_bubble", {31'd0, out_valid}, 32'd1);
        chk("t2_tag_order", {28'd0, out_tag}, 32'(k - 2));
      end
    end
    in_valid = 1'b0;
    step();

    // 3: backpressure fills S2, S1 and the FIFO.
    out_ready = 1'b0;
    push_n(6, 4'd8, accepted);
    chk("t3_accepted", 32'(accepted), 32'd6);
    repeat (2) step();
    chk("t3_fifo_full", {29'd0, fifo_count}, 32'd4);
    chk("t3_in_ready_low", {31'd0, in_ready}, 32'd0);
    chk("t3_out_valid", {31'd0, out_valid}, 32'd1);
    chk("t3_first_tag", {28'd0, out_tag}, 32'd8);
    held_res = out_result;
    held_a   = fpu_a;
    repeat (3) step();
    chk("t3_result_stable", out_result, held_res);
    chk("t3_fpu_a_stable", fpu_a, held_a);
    out_ready = 1'b1;
    for (int c = 0; c < 20 && q.size() != 0; c++) step();
    chk("t3_drained", 32'(q.size()), 32'd0);

    // 4: class flags through the pass-through opcode.
    for (int i = 0; i < 3; i++) begin
      drive(specials[i], 32'h0, 3'd7, 4'd14);
      step();
      in_valid = 1'b0;
      for (int c = 0; c < 10 && !out_valid; c++) step();
      chk("t4_valid", {31'd0, out_valid}, 32'd1);
      chk("t4_flags", {29'd0, out_zero, out_inf, out_nan}, {29'd0, spec_flags[i]});
      step();
    end

    // 5: flush with everything occupied plus a push in the same cycle.
    out_ready = 1'b0;
    push_n(5, 4'd0, accepted);
    repeat (2) step();
    chk("t5_fifo_3", {29'd0, fifo_count}, 32'd3);
    chk("t5_s2_full", {31'd0, out_valid}, 32'd1);
    flush = 1'b1;
    drive(32'h1234_5678, 32'h0, 3'd1, 4'd15);
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("t5_out_valid_clr", {31'd0, out_valid}, 32'd0);
    chk("t5_fifo_clr", {29'd0, fifo_count}, 32'd0);
    out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      step();
      chk("t5_no_stale", {31'd0, out_valid}, 32'd0);
    end

    // 6: random traffic with an asynchronous reset in the middle.
    for (int c = 0; c < 300; c++) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_a      = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 2)] : $urandom;
      in_b      = $urandom;
      in_opcode = 3'($urandom_range(1, 7));
      in_tag    = 4'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      step();
      if (c == 150) begin
        #2;
        rst = 1'b1;
        #1;
        check_reset_values("t6_async");
        step();
        rst = 1'b0;
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 50 && q.size() != 0; c++) step();
    chk("t6_drained", 32'(q.size()), 32'd0);
    repeat (2) step();
    chk("t6_idle", {31'd0, out_valid}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
